// File: rtl/freq_counter_poller.sv
// Autonomous Avalon-MM read master that periodically samples the frequency counter's
// measured-count register, checks it against a window and filters the result into a lock status.
module freq_counter_poller #(
    parameter int unsigned POLL_INTERVAL = 1024,
    parameter int unsigned READ_LATENCY  = 1,
    parameter logic [3:0]  COUNT_ADDR    = 4'd0,
    parameter int unsigned LOCK_COUNT    = 4,
    parameter int unsigned UNLOCK_COUNT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] min_count,
    input  logic [31:0] max_count,
    output logic [3:0]  csr_address,
    output logic        csr_read,
    input  logic [31:0] csr_readdata,
    output logic [31:0] sample_value,
    output logic        sample_valid,
    output logic        in_range,
    output logic        locked,
    output logic        lock_lost
);

    localparam int unsigned        TIMER_W       = (POLL_INTERVAL > 2) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST    = TIMER_W'(POLL_INTERVAL - 1);
    localparam logic [TIMER_W-1:0] TIMER_ZERO    = TIMER_W'(0);
    localparam logic [2:0]         WAIT_LAST     = 3'(READ_LATENCY - 1);
    localparam logic [7:0]         LOCK_THRESH   = 8'(LOCK_COUNT);
    localparam logic [7:0]         UNLOCK_THRESH = 8'(UNLOCK_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        if (v == 8'hFF) begin
            sat_inc = v;
        end else begin
            sat_inc = v + 8'd1;
        end
    endfunction

    // An inverted window (lo > hi) can never match, so it needs no special case.
    function automatic logic window_hit(input logic [31:0] v, input logic [31:0] lo, input logic [31:0] hi);
        window_hit = (lo <= v) && (v <= hi);
    endfunction

    state_t                state_r;
    state_t                next_state_s;
    logic [TIMER_W-1:0]    timer_r;
    logic [2:0]            wait_cnt_r;
    logic                  launch_s;
    logic                  capture_s;
    logic                  hit_s;
    logic [7:0]            in_cnt_r;
    logic [7:0]            out_cnt_r;
    logic [7:0]            in_cnt_next_s;
    logic [7:0]            out_cnt_next_s;
    logic                  locked_next_s;
    logic                  lock_lost_next_s;
    logic                  csr_read_next_s;
    logic                  csr_read_r;
    logic [31:0]           sample_value_r;
    logic                  sample_valid_r;
    logic                  in_range_r;
    logic                  locked_r;
    logic                  lock_lost_r;

    assign launch_s  = enable && (timer_r == TIMER_LAST);
    assign capture_s = (state_r == ST_WAIT) && (wait_cnt_r == WAIT_LAST);
    assign hit_s     = window_hit(csr_readdata, min_count, max_count);

    // Poll interval timer, held at zero while polling is disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_r <= TIMER_ZERO;
        end else if (!enable) begin
            timer_r <= TIMER_ZERO;
        end else if (timer_r == TIMER_LAST) begin
            timer_r <= TIMER_ZERO;
        end else begin
            timer_r <= timer_r + 1'b1;
        end
    end

    // FSM state register and read-latency counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= 3'd0;
        end else begin
            state_r    <= next_state_s;
            wait_cnt_r <= (state_r == ST_WAIT) ? (wait_cnt_r + 3'd1) : 3'd0;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (launch_s) begin
                    next_state_s = ST_READ;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_READ: next_state_s = ST_WAIT;
            ST_WAIT: begin
                if (wait_cnt_r == WAIT_LAST) begin
                    next_state_s = ST_UPDATE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_UPDATE: next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs and hysteresis counters.
    always_comb begin
        csr_read_next_s  = (next_state_s == ST_READ);
        in_cnt_next_s    = in_cnt_r;
        out_cnt_next_s   = out_cnt_r;
        locked_next_s    = locked_r;
        lock_lost_next_s = 1'b0;
        if (!enable) begin
            // Disabling drops lock silently; an in-flight sample leaves the counters alone.
            in_cnt_next_s  = 8'd0;
            out_cnt_next_s = 8'd0;
            locked_next_s  = 1'b0;
        end else if (capture_s) begin
            if (hit_s) begin
                in_cnt_next_s  = sat_inc(in_cnt_r);
                out_cnt_next_s = 8'd0;
                if (sat_inc(in_cnt_r) >= LOCK_THRESH) begin
                    locked_next_s = 1'b1;
                end else begin
                    locked_next_s = locked_r;
                end
            end else begin
                in_cnt_next_s  = 8'd0;
                out_cnt_next_s = sat_inc(out_cnt_r);
                if (locked_r && (sat_inc(out_cnt_r) >= UNLOCK_THRESH)) begin
                    locked_next_s    = 1'b0;
                    lock_lost_next_s = 1'b1;
                end else begin
                    locked_next_s = locked_r;
                end
            end
        end else begin
            in_cnt_next_s = in_cnt_r;
        end
    end

    // Output and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            csr_read_r     <= 1'b0;
            sample_value_r <= 32'd0;
            sample_valid_r <= 1'b0;
            in_range_r     <= 1'b0;
            locked_r       <= 1'b0;
            lock_lost_r    <= 1'b0;
            in_cnt_r       <= 8'd0;
            out_cnt_r      <= 8'd0;
        end else begin
            csr_read_r     <= csr_read_next_s;
            sample_valid_r <= capture_s;
            if (capture_s) begin
                sample_value_r <= csr_readdata;
                in_range_r     <= hit_s;
            end
            locked_r    <= locked_next_s;
            lock_lost_r <= lock_lost_next_s;
            in_cnt_r    <= in_cnt_next_s;
            out_cnt_r   <= out_cnt_next_s;
        end
    end

    assign csr_address  = COUNT_ADDR;
    assign csr_read     = csr_read_r;
    assign sample_value = sample_value_r;
    assign sample_valid = sample_valid_r;
    assign in_range     = in_range_r;
    assign locked       = locked_r;
    assign lock_lost    = lock_lost_r;

endmodule

// File: tb/tb_freq_counter_poller.sv
// Directed bench for freq_counter_poller: one instance with READ_LATENCY=1 and one with 3,
// sharing clock and stimulus; the slave is modelled as a held csr_readdata value.
module tb_freq_counter_poller;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] min_count;
    logic [31:0] max_count;
    logic [31:0] csr_readdata;

    logic [3:0]  csr_address;
    logic        csr_read;
    logic [31:0] sample_value;
    logic        sample_valid;
    logic        in_range;
    logic        locked;
    logic        lock_lost;

    logic [3:0]  l3_csr_address;
    logic        l3_csr_read;
    logic [31:0] l3_sample_value;
    logic        l3_sample_valid;
    logic        l3_in_range;
    logic        l3_locked;
    logic        l3_lock_lost;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    freq_counter_poller #(
        .POLL_INTERVAL(16), .READ_LATENCY(1), .COUNT_ADDR(4'd0), .LOCK_COUNT(3), .UNLOCK_COUNT(2)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .min_count(min_count), .max_count(max_count),
        .csr_address(csr_address), .csr_read(csr_read), .csr_readdata(csr_readdata),
        .sample_value(sample_value), .sample_valid(sample_valid), .in_range(in_range),
        .locked(locked), .lock_lost(lock_lost)
    );

    freq_counter_poller #(
        .POLL_INTERVAL(16), .READ_LATENCY(3), .COUNT_ADDR(4'd0), .LOCK_COUNT(3), .UNLOCK_COUNT(2)
    ) dut_l3 (
        .clk(clk), .reset(reset), .enable(enable), .min_count(min_count), .max_count(max_count),
        .csr_address(l3_csr_address), .csr_read(l3_csr_read), .csr_readdata(csr_readdata),
        .sample_value(l3_sample_value), .sample_valid(l3_sample_valid), .in_range(l3_in_range),
        .locked(l3_locked), .lock_lost(l3_lock_lost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic restart();
        reset  = 1'b1;
        enable = 1'b0;
        tick();
        tick();
        reset  = 1'b0;
        enable = 1'b1;
        cyc    = 0;
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b0;
        min_count    = 32'd990;
        max_count    = 32'd1010;
        csr_readdata = 32'd1000;
        tick();
        tick();
        tick();
        chk("rst_csr_read", csr_read, 32'd0);
        chk("rst_csr_address", csr_address, 32'd0);
        chk("rst_sample_value", sample_value, 32'd0);
        chk("rst_sample_valid", sample_valid, 32'd0);
        chk("rst_in_range", in_range, 32'd0);
        chk("rst_locked", locked, 32'd0);
        chk("rst_lock_lost", lock_lost, 32'd0);

        // Timing and lock acquisition: enable high from cycle 0.
        restart();
        go_to(15); chk("read_c15", csr_read, 32'd0);
        go_to(16); chk("read_c16", csr_read, 32'd1);
        chk("addr_c16", csr_address, 32'd0);
        go_to(17); chk("read_c17", csr_read, 32'd0);
        chk("valid_c17", sample_valid, 32'd0);
        go_to(18); chk("valid_c18", sample_valid, 32'd1);
        chk("value_c18", sample_value, 32'd1000);
        chk("inrange_c18", in_range, 32'd1);
        chk("locked_c18", locked, 32'd0);
        go_to(19); chk("valid_c19", sample_valid, 32'd0);
        chk("l3_valid_c19", l3_sample_valid, 32'd0);
        go_to(20); chk("l3_valid_c20", l3_sample_valid, 32'd1);
        chk("l3_value_c20", l3_sample_value, 32'd1000);
        go_to(21); chk("l3_valid_c21", l3_sample_valid, 32'd0);
        go_to(31); chk("read_c31", csr_read, 32'd0);
        go_to(32); chk("read_c32", csr_read, 32'd1);
        go_to(34); chk("locked_c34", locked, 32'd0);
        go_to(48); chk("read_c48", csr_read, 32'd1);
        go_to(49); chk("read_c49", csr_read, 32'd0);
        chk("locked_c49", locked, 32'd0);
        go_to(50); chk("locked_c50", locked, 32'd1);
        chk("valid_c50", sample_valid, 32'd1);
        chk("lost_c50", lock_lost, 32'd0);

        // Hysteresis: samples 1000, 2000, 1000, 2000, 2000 at updates 66..130.
        go_to(66); chk("hys_locked_66", locked, 32'd1);
        go_to(70); csr_readdata = 32'd2000;
        go_to(82); chk("hys_inrange_82", in_range, 32'd0);
        chk("hys_locked_82", locked, 32'd1);
        chk("hys_lost_82", lock_lost, 32'd0);
        go_to(86); csr_readdata = 32'd1000;
        go_to(98); chk("hys_inrange_98", in_range, 32'd1);
        chk("hys_locked_98", locked, 32'd1);
        go_to(102); csr_readdata = 32'd2000;
        go_to(114); chk("hys_locked_114", locked, 32'd1);
        chk("hys_lost_114", lock_lost, 32'd0);
        go_to(130); chk("hys_locked_130", locked, 32'd0);
        chk("hys_lost_130", lock_lost, 32'd1);
        chk("hys_value_130", sample_value, 32'd2000);
        go_to(131); chk("hys_lost_131", lock_lost, 32'd0);

        // Window boundaries, inverted window and extreme values.
        go_to(134); csr_readdata = 32'd990;
        go_to(146); chk("bnd_990", in_range, 32'd1);
        go_to(150); csr_readdata = 32'd1010;
        go_to(162); chk("bnd_1010", in_range, 32'd1);
        go_to(166); csr_readdata = 32'd989;
        go_to(178); chk("bnd_989", in_range, 32'd0);
        go_to(182); csr_readdata = 32'd1011;
        go_to(194); chk("bnd_1011", in_range, 32'd0);
        go_to(198); min_count = 32'd5; max_count = 32'd4; csr_readdata = 32'd5;
        go_to(210); chk("bnd_inverted", in_range, 32'd0);
        chk("bnd_inverted_value", sample_value, 32'd5);
        go_to(214); min_count = 32'd0; max_count = 32'hFFFF_FFFF; csr_readdata = 32'd0;
        go_to(226); chk("bnd_zero", in_range, 32'd1);
        chk("bnd_zero_value", sample_value, 32'd0);
        go_to(230); csr_readdata = 32'hFFFF_FFFF;
        go_to(242); chk("bnd_ones", in_range, 32'd1);
        chk("bnd_ones_value", sample_value, 32'hFFFF_FFFF);

        // Enable drop with a read in flight, then re-enable.
        min_count    = 32'd990;
        max_count    = 32'd1010;
        csr_readdata = 32'd1000;
        restart();
        go_to(50); chk("en_locked_50", locked, 32'd1);
        go_to(64); chk("en_read_64", csr_read, 32'd1);
        go_to(65); chk("en_locked_65", locked, 32'd1);
        enable = 1'b0;
        go_to(66); chk("en_valid_66", sample_valid, 32'd1);
        chk("en_inrange_66", in_range, 32'd1);
        chk("en_locked_66", locked, 32'd0);
        chk("en_lost_66", lock_lost, 32'd0);
        for (int c = 67; c <= 77; c++) begin
            go_to(c);
            chk("en_no_read_off", csr_read, 32'd0);
            chk("en_no_lost_off", lock_lost, 32'd0);
        end
        go_to(78); enable = 1'b1;
        for (int c = 79; c <= 93; c++) begin
            go_to(c);
            chk("en_no_read_restart", csr_read, 32'd0);
        end
        go_to(94); chk("en_read_94", csr_read, 32'd1);
        go_to(96); chk("en_valid_96", sample_valid, 32'd1);
        chk("en_locked_96", locked, 32'd0);
        go_to(112); chk("en_locked_112", locked, 32'd0);
        go_to(128); chk("en_locked_128", locked, 32'd1);

        // Reset during the csr_read cycle.
        go_to(142); chk("rm_read_142", csr_read, 32'd1);
        reset = 1'b1;
        go_to(143); chk("rm_read_143", csr_read, 32'd0);
        chk("rm_value_143", sample_value, 32'd0);
        chk("rm_valid_143", sample_valid, 32'd0);
        chk("rm_inrange_143", in_range, 32'd0);
        chk("rm_locked_143", locked, 32'd0);
        chk("rm_lost_143", lock_lost, 32'd0);
        chk("rm_addr_143", csr_address, 32'd0);
        reset = 1'b0;
        go_to(144); chk("rm_valid_144", sample_valid, 32'd0);
        go_to(145); chk("rm_valid_145", sample_valid, 32'd0);
        go_to(158); chk("rm_read_158", csr_read, 32'd0);
        go_to(159); chk("rm_read_159", csr_read, 32'd1);
        go_to(161); chk("rm_valid_161", sample_valid, 32'd1);
        chk("rm_locked_161", locked, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
